// File: rtl/pwm_deadtime_gen_pkg.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen_pkg
//   Shared definitions for the PWM dead-time gate driver: FSM state encoding
//   and the legal DEAD_TIME range. Kept in a package so a multi-leg top can
//   reuse the same encoding and limits.
// -----------------------------------------------------------------------------
package pwm_deadtime_gen_pkg;

    // Gate FSM state encoding
    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_DT_HI = 3'd1;  // both gates off, waiting to turn on hi
    localparam logic [2:0] ST_HI    = 3'd2;
    localparam logic [2:0] ST_DT_LO = 3'd3;  // both gates off, waiting to turn on lo
    localparam logic [2:0] ST_LO    = 3'd4;

    // Legal dead-time range in clock cycles
    localparam int DEAD_TIME_MIN = 1;
    localparam int DEAD_TIME_MAX = 255;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen_if
//   Bundles the carrier/duty inputs, run/fault controls and gate/status
//   outputs of one converter leg.
//   master: drives carrier, duty, duty_load, enable, fault, fault_clr;
//           observes gate_hi, gate_lo, duty_active, sync_pulse, fault_latched.
//   slave : the gate driver itself (opposite directions).
// -----------------------------------------------------------------------------
interface pwm_deadtime_gen_if #(
    parameter int MAX_COUNT = 16
);
    localparam int CW = $clog2(MAX_COUNT);
    localparam int DW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] carrier;
    logic [DW-1:0] duty;
    logic          duty_load;
    logic          enable;
    logic          fault;
    logic          fault_clr;
    logic          gate_hi;
    logic          gate_lo;
    logic [DW-1:0] duty_active;
    logic          sync_pulse;
    logic          fault_latched;

    modport master (
        output carrier, duty, duty_load, enable, fault, fault_clr,
        input  gate_hi, gate_lo, duty_active, sync_pulse, fault_latched
    );

    modport slave (
        input  carrier, duty, duty_load, enable, fault, fault_clr,
        output gate_hi, gate_lo, duty_active, sync_pulse, fault_latched
    );

endinterface

// File: rtl/pwm_deadtime_gen_dead_time_timer.sv
// -----------------------------------------------------------------------------
// dead_time_timer
//   Loadable down-counter used to time the both-gates-off interval.
//   Ports:
//     clk_in  in  clock
//     reset   in  synchronous active-high reset (count -> 0)
//     load    in  loads 'value' into the counter
//     value   in  TW  value to load
//     expired out asserted while the count is 1, i.e. in the last dead cycle
// -----------------------------------------------------------------------------
module dead_time_timer #(
    parameter int TW = 2
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expired = (count == TW'(1));

endmodule

// File: rtl/pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen
//   Complementary gate driver for one converter leg. Compares the carrier
//   against a double-buffered duty reference, inserts DEAD_TIME cycles with
//   both gates off at every hand-over, and shuts down on a latched fault.
//   Ports:
//     clk_in  in  system clock
//     reset   in  synchronous active-high reset
//     bus     slave modport of pwm_deadtime_gen_if:
//             carrier, duty, duty_load, enable, fault, fault_clr (in)
//             gate_hi, gate_lo, duty_active, sync_pulse, fault_latched (out)
// -----------------------------------------------------------------------------
module pwm_deadtime_gen
    import pwm_deadtime_gen_pkg::*;
#(
    parameter int MAX_COUNT = 16,
    parameter int DEAD_TIME = 3
) (
    input  logic               clk_in,
    input  logic               reset,
    pwm_deadtime_gen_if.slave  bus
);

    localparam int CW = $clog2(MAX_COUNT);
    localparam int DW = $clog2(MAX_COUNT + 1);
    localparam int TW = $clog2(DEAD_TIME + 1);
    localparam logic [DW-1:0] MAX_DUTY = DW'(MAX_COUNT);

    generate
        if (DEAD_TIME < DEAD_TIME_MIN || DEAD_TIME > DEAD_TIME_MAX) begin : g_bad_dead_time
            $error("pwm_deadtime_gen: DEAD_TIME must be within 1..255");
        end
    endgenerate

    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] d);
        return (d > MAX_DUTY) ? MAX_DUTY : d;
    endfunction

    logic [DW-1:0] duty_pending;
    logic [DW-1:0] duty_active_p1;
    logic          carrier_nz_p1;
    logic          req_hi_p1;
    logic          sync_p1;
    logic          boundary;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          timer_load;
    logic          timer_expired;
    logic          gate_hi_q;
    logic          gate_lo_q;
    logic          fault_latched_q;

    // A period starts on the first zero carrier after a non-zero one, so a
    // carrier parked at 0 does not keep reloading the active duty.
    assign boundary = (bus.carrier == '0) && carrier_nz_p1;

    // ---- stage p1: shadow duty, period detect, registered compare ----
    always_ff @(posedge clk_in) begin
        if (reset) begin
            duty_pending   <= '0;
            duty_active_p1 <= '0;
            carrier_nz_p1  <= 1'b0;
            req_hi_p1      <= 1'b0;
            sync_p1        <= 1'b0;
        end else begin
            if (bus.duty_load) begin
                duty_pending <= clamp_duty(bus.duty);
            end
            // Old pending transfers even when a load lands in the boundary cycle
            if (boundary) begin
                duty_active_p1 <= duty_pending;
            end
            sync_p1       <= boundary;
            carrier_nz_p1 <= (bus.carrier != '0);
            req_hi_p1     <= (DW'(bus.carrier) < duty_active_p1);
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        if (bus.fault || fault_latched_q || !bus.enable) begin
            state_next = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    state_next = req_hi_p1 ? ST_DT_HI : ST_DT_LO;
                    timer_load = 1'b1;
                end
                ST_HI: begin
                    if (!req_hi_p1) begin
                        state_next = ST_DT_LO;
                        timer_load = 1'b1;
                    end
                end
                ST_LO: begin
                    if (req_hi_p1) begin
                        state_next = ST_DT_HI;
                        timer_load = 1'b1;
                    end
                end
                ST_DT_HI: begin
                    // Demand reversal restarts the full dead time
                    if (!req_hi_p1) begin
                        state_next = ST_DT_LO;
                        timer_load = 1'b1;
                    end else if (timer_expired) begin
                        state_next = ST_HI;
                    end
                end
                ST_DT_LO: begin
                    if (req_hi_p1) begin
                        state_next = ST_DT_HI;
                        timer_load = 1'b1;
                    end else if (timer_expired) begin
                        state_next = ST_LO;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                end
            endcase
        end
    end

    // ---- stage p2: FSM state, registered gates, fault latch ----
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state           <= ST_OFF;
            gate_hi_q       <= 1'b0;
            gate_lo_q       <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state     <= state_next;
            // Decoded from the next state so the gates are flops, never both 1
            gate_hi_q <= (state_next == ST_HI);
            gate_lo_q <= (state_next == ST_LO);
            if (bus.fault) begin
                fault_latched_q <= 1'b1;
            end else if (bus.fault_clr) begin
                fault_latched_q <= 1'b0;
            end
        end
    end

    dead_time_timer #(
        .TW (TW)
    ) u_dead_time_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .load    (timer_load),
        .value   (TW'(DEAD_TIME)),
        .expired (timer_expired)
    );

    assign bus.gate_hi       = gate_hi_q;
    assign bus.gate_lo       = gate_lo_q;
    assign bus.duty_active   = duty_active_p1;
    assign bus.sync_pulse    = sync_p1;
    assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gen
//   Bench for pwm_deadtime_gen (MAX_COUNT=16, DEAD_TIME=3). The reference
//   model tracks the duty buffering and fault latch directly, and derives the
//   gates from a window rule: a gate is on in a cycle exactly when its demand
//   has been present, with running permitted, for each of the previous
//   DEAD_TIME+1 cycles.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

    localparam int MAX_COUNT = 16;
    localparam int DEAD_TIME = 3;
    localparam int CW = $clog2(MAX_COUNT);
    localparam int DW = $clog2(MAX_COUNT + 1);
    localparam logic [31:0] WIN = (32'd1 << (DEAD_TIME + 1)) - 32'd1;

    logic clk_in = 1'b0;
    logic reset;

    pwm_deadtime_gen_if #(.MAX_COUNT(MAX_COUNT)) bus ();

    pwm_deadtime_gen #(
        .MAX_COUNT (MAX_COUNT),
        .DEAD_TIME (DEAD_TIME)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        assert (!(bus.gate_hi && bus.gate_lo)) else $error("gate overlap at %0t", $time);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int saw      = 0;

    // reference model state
    logic [DW-1:0] m_pending = '0;
    logic [DW-1:0] m_active  = '0;
    logic          m_prev_nz = 1'b0;
    logic          m_req     = 1'b0;
    logic          m_fl      = 1'b0;
    logic          m_sync    = 1'b0;
    logic [31:0]   hist_hi   = '0;
    logic [31:0]   hist_lo   = '0;

    task automatic check_val(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    endtask

    // Advance one clock: update the model from the inputs present before the
    // edge, then compare all outputs shortly after it.
    task automatic tick();
        logic allowed;
        logic boundary;
        logic exp_hi;
        logic exp_lo;
        allowed = !reset && !bus.fault && !m_fl && bus.enable;
        hist_hi = {hist_hi[30:0], m_req && allowed};
        hist_lo = {hist_lo[30:0], !m_req && allowed};
        exp_hi  = ((hist_hi & WIN) == WIN);
        exp_lo  = ((hist_lo & WIN) == WIN);
        if (reset) begin
            m_pending = '0;
            m_active  = '0;
            m_prev_nz = 1'b0;
            m_req     = 1'b0;
            m_fl      = 1'b0;
            m_sync    = 1'b0;
        end else begin
            boundary  = (bus.carrier == '0) && m_prev_nz;
            m_req     = (int'(bus.carrier) < int'(m_active));
            m_sync    = boundary;
            if (boundary) m_active = m_pending;
            if (bus.duty_load)
                m_pending = (int'(bus.duty) > MAX_COUNT) ? DW'(MAX_COUNT) : bus.duty;
            m_prev_nz = (bus.carrier != '0);
            if (bus.fault) m_fl = 1'b1;
            else if (bus.fault_clr) m_fl = 1'b0;
        end
        @(posedge clk_in);
        #1;
        check_val("gate_hi", bus.gate_hi, exp_hi);
        check_val("gate_lo", bus.gate_lo, exp_lo);
        check_val("duty_active", bus.duty_active, m_active);
        check_val("sync_pulse", bus.sync_pulse, m_sync);
        check_val("fault_latched", bus.fault_latched, m_fl);
        check_val("no_overlap", bus.gate_hi & bus.gate_lo, 0);
    endtask

    task automatic saw_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.carrier = CW'(saw);
            tick();
            saw = (saw + 1) % MAX_COUNT;
        end
    endtask

    task automatic load_duty(input int d);
        bus.duty      = DW'(d);
        bus.duty_load = 1'b1;
        saw_ticks(1);
        bus.duty_load = 1'b0;
    endtask

    initial begin
        int cnt_hi;
        int cnt_lo;
        int cnt_off;
        int w;

        reset         = 1'b1;
        bus.carrier   = '0;
        bus.duty      = '0;
        bus.duty_load = 1'b0;
        bus.enable    = 1'b1;
        bus.fault     = 1'b1;
        bus.fault_clr = 1'b0;

        // 1: reset held with fault and enable asserted
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("p1_reset_hi", bus.gate_hi, 0);
            check_val("p1_reset_fl", bus.fault_latched, 0);
            check_val("p1_reset_duty", bus.duty_active, 0);
        end
        reset     = 1'b0;
        bus.fault = 1'b0;

        // 2: duty 8, steady switching
        saw = 0;
        load_duty(8);
        saw_ticks(16);
        check_val("p2_active", bus.duty_active, 8);
        saw_ticks(32);
        cnt_hi = 0;
        cnt_lo = 0;
        for (int i = 0; i < MAX_COUNT; i++) begin
            saw_ticks(1);
            cnt_hi += int'(bus.gate_hi);
            cnt_lo += int'(bus.gate_lo);
        end
        check_val("p2_hi_cycles", cnt_hi, 5);
        check_val("p2_lo_cycles", cnt_lo, 5);

        // 3: mid-period load waits for the next boundary
        while (saw != 5) saw_ticks(1);
        load_duty(12);
        while (saw != 0) begin
            saw_ticks(1);
            check_val("p3_hold", bus.duty_active, 8);
        end
        saw_ticks(1);
        check_val("p3_reload", bus.duty_active, 12);
        check_val("p3_sync", bus.sync_pulse, 1);
        saw_ticks(1);
        check_val("p3_sync_end", bus.sync_pulse, 0);

        // 4: fault while gate_hi, latch, clear, restart through dead time
        w = 0;
        while (!bus.gate_hi && w < 64) begin
            saw_ticks(1);
            w++;
        end
        check_val("p4_gate_hi_seen", bus.gate_hi, 1);
        bus.fault = 1'b1;
        saw_ticks(1);
        check_val("p4_drop_hi", bus.gate_hi, 0);
        check_val("p4_drop_lo", bus.gate_lo, 0);
        check_val("p4_latched", bus.fault_latched, 1);
        saw_ticks(1);
        bus.fault = 1'b0;
        saw_ticks(20);
        check_val("p4_still_latched", bus.fault_latched, 1);
        while (saw != 1) saw_ticks(1);
        bus.fault_clr = 1'b1;
        saw_ticks(1);
        bus.fault_clr = 1'b0;
        check_val("p4_cleared", bus.fault_latched, 0);
        for (int i = 0; i < DEAD_TIME; i++) begin
            saw_ticks(1);
            check_val("p4_dead_off", bus.gate_hi | bus.gate_lo, 0);
        end
        saw_ticks(1);
        check_val("p4_resume_hi", bus.gate_hi, 1);

        // 5: duty extremes and clamping
        load_duty(0);
        saw_ticks(48);
        cnt_lo = 0;
        for (int i = 0; i < MAX_COUNT; i++) begin
            saw_ticks(1);
            cnt_lo += int'(bus.gate_lo);
        end
        check_val("p5_lo_full", cnt_lo, MAX_COUNT);
        load_duty(16);
        saw_ticks(48);
        cnt_hi = 0;
        for (int i = 0; i < MAX_COUNT; i++) begin
            saw_ticks(1);
            cnt_hi += int'(bus.gate_hi);
        end
        check_val("p5_hi_full", cnt_hi, MAX_COUNT);
        load_duty(20);
        saw_ticks(32);
        check_val("p5_clamp", bus.duty_active, 16);

        // 6: one-cycle demand blip reverses DT_HI into DT_LO
        load_duty(8);
        saw_ticks(32);
        bus.carrier = CW'(15);
        for (int i = 0; i < 8; i++) tick();
        check_val("p6_lo_before", bus.gate_lo, 1);
        bus.carrier = CW'(2);
        tick();
        bus.carrier = CW'(15);
        cnt_off = 0;
        cnt_hi  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt_off += int'(!bus.gate_hi && !bus.gate_lo);
            cnt_hi  += int'(bus.gate_hi);
        end
        check_val("p6_off_cycles", cnt_off, DEAD_TIME + 1);
        check_val("p6_no_hi", cnt_hi, 0);
        check_val("p6_lo_after", bus.gate_lo, 1);
        saw = 0;

        // 7: randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.carrier = CW'($urandom_range(0, MAX_COUNT - 1));
            end else begin
                bus.carrier = CW'(saw);
                saw = (saw + 1) % MAX_COUNT;
            end
            bus.duty_load = ($urandom_range(0, 15) == 0);
            bus.duty      = DW'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) bus.enable = !bus.enable;
            bus.fault     = ($urandom_range(0, 99) < 2);
            bus.fault_clr = ($urandom_range(0, 19) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
